// File: rtl/mem_arbiter_if.sv
// Bus bundle between the datapath, the memory arbiter and the shared RAM port.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives requests and models the RAM (datapath plus memory).
// Optional macro MEM_ARB_PERF_EN adds the icount/dcount/stall_cnt counters.
interface mem_arbiter_if #(
  parameter int WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic [WORD_W-1:0] iload;
  logic              ihit;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [WORD_W-1:0] dload;
  logic              dhit;
  logic              ram_REN;
  logic              ram_WEN;
  logic [WORD_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_store;
  logic [WORD_W-1:0] ram_load;
  logic              ram_ready;
  logic              err;
`ifdef MEM_ARB_PERF_EN
  logic [WORD_W-1:0] icount;
  logic [WORD_W-1:0] dcount;
  logic [WORD_W-1:0] stall_cnt;
`endif

`ifdef MEM_ARB_PERF_EN
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output iload, ihit, dload, dhit, ram_REN, ram_WEN, ram_addr, ram_store, err,
    output icount, dcount, stall_cnt
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  iload, ihit, dload, dhit, ram_REN, ram_WEN, ram_addr, ram_store, err,
    input  icount, dcount, stall_cnt
  );
`else
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output iload, ihit, dload, dhit, ram_REN, ram_WEN, ram_addr, ram_store, err
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  iload, ihit, dload, dhit, ram_REN, ram_WEN, ram_addr, ram_store, err
  );
`endif
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises instruction-fetch and data accesses
// onto one RAM port, data first, with a one-cycle DONE turnaround that carries
// the hit (or watchdog error) pulse. An access that sees MAX_WAIT consecutive
// not-ready cycles is aborted and reported on err.
// Optional macro MEM_ARB_PERF_EN adds saturating hit and stall counters.
module mem_arbiter #(
  parameter int WORD_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} state_t;
  typedef enum logic [1:0] {DONE_NONE, DONE_I, DONE_D, DONE_ERR} done_t;

  // Wait counter is 8 bits since MAX_WAIT is limited to 255.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  done_t             done_q, done_d;
  logic              op_write_q, op_write_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic [WORD_W-1:0] iload_q, iload_d;
  logic [WORD_W-1:0] dload_q, dload_d;
  logic [7:0]        wait_q, wait_d;
  logic              ram_ren, ram_wen;
  logic              in_access;

  assign in_access = (state_q == IACC) || (state_q == DACC);

  // State and datapath registers; reset also drops any in-flight access.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      done_q     <= DONE_NONE;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      store_q    <= '0;
      iload_q    <= '0;
      dload_q    <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      wait_q     <= wait_d;
    end
  end

  // Next-state, latch and strobe logic; requests are only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    store_d    = store_q;
    iload_d    = iload_q;
    dload_d    = dload_q;
    wait_d     = wait_q;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          addr_d     = bus.daddr;
          store_d    = bus.dstore;
          op_write_d = bus.dWEN;
          state_d    = DACC;
        end else if (bus.iREN) begin
          addr_d  = bus.iaddr;
          state_d = IACC;
        end
      end
      IACC, DACC: begin
        ram_ren = (state_q == IACC) || !op_write_q;
        ram_wen = (state_q == DACC) && op_write_q;
        if (bus.ram_ready) begin
          if (state_q == IACC) begin
            iload_d = bus.ram_load;
            done_d  = DONE_I;
          end else begin
            if (!op_write_q) begin
              dload_d = bus.ram_load;
            end
            done_d = DONE_D;
          end
          wait_d  = '0;
          state_d = DONE;
        end else if (wait_q == WAIT_LAST) begin
          done_d  = DONE_ERR;
          wait_d  = '0;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ram_REN   = ram_ren;
  assign bus.ram_WEN   = ram_wen;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_store = store_q;
  assign bus.iload     = iload_q;
  assign bus.dload     = dload_q;
  assign bus.ihit      = (state_q == DONE) && (done_q == DONE_I);
  assign bus.dhit      = (state_q == DONE) && (done_q == DONE_D);
  assign bus.err       = (state_q == DONE) && (done_q == DONE_ERR);

`ifdef MEM_ARB_PERF_EN
  logic [WORD_W-1:0] icount_q, dcount_q, stall_q;

  // Saturating completion and stall counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
      stall_q  <= '0;
    end else begin
      if (bus.ihit && (icount_q != '1)) begin
        icount_q <= icount_q + 1'b1;
      end
      if (bus.dhit && (dcount_q != '1)) begin
        dcount_q <= dcount_q + 1'b1;
      end
      if (in_access && !bus.ram_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.icount    = icount_q;
  assign bus.dcount    = dcount_q;
  assign bus.stall_cnt = stall_q;
`else
  logic unused_access;
  assign unused_access = in_access;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of directed transactions,
// hand-written multi-cycle corner cases, and randomized transactions whose
// expected outcome comes from a transaction-level timing model.
module tb_mem_arbiter;

  localparam int WORD_W   = 32;
  localparam int MAX_WAIT = 4;

  localparam int K_IREAD  = 0;
  localparam int K_DREAD  = 1;
  localparam int K_DWRITE = 2;
  localparam int K_DBOTH  = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
    int          waits;
    logic        exp_ihit;
    logic        exp_dhit;
    logic        exp_err;
    int          done_cyc;
    logic [31:0] exp_iload;
    logic [31:0] exp_dload;
  } vec_t;

  logic CLK;
  logic nRST;
  int   tests;
  int   failures;
  logic [31:0] model_iload;
  logic [31:0] model_dload;
  vec_t vecs[8];

  mem_arbiter_if #(.WORD_W(WORD_W)) bus ();

  mem_arbiter #(.WORD_W(WORD_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // Free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_output({tag, " ram_REN"}, 32'(bus.ram_REN), 32'd0);
    check_output({tag, " ram_WEN"}, 32'(bus.ram_WEN), 32'd0);
    check_output({tag, " hits"}, {29'd0, bus.ihit, bus.dhit, bus.err}, 32'd0);
  endtask

  task automatic clear_requests();
    bus.iREN   = 1'b0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.iaddr  = $urandom;
    bus.daddr  = $urandom;
    bus.dstore = $urandom;
  endtask

  // Drives one transaction from IDLE and checks every cycle up to the
  // following IDLE against the supplied expectations.
  task automatic apply_stimulus(input int kind, input logic [31:0] addr, input logic [31:0] store,
                                input logic [31:0] rdata, input int waits,
                                input logic exp_ihit, input logic exp_dhit, input logic exp_err,
                                input int done_cyc, input logic [31:0] exp_iload,
                                input logic [31:0] exp_dload);
    logic is_write;
    logic is_read;
    is_write = (kind == K_DWRITE) || (kind == K_DBOTH);
    is_read  = !is_write;
    clear_requests();
    if (kind == K_IREAD) begin
      bus.iREN  = 1'b1;
      bus.iaddr = addr;
      bus.daddr = ~addr;
    end else begin
      bus.iaddr  = ~addr;
      bus.daddr  = addr;
      bus.dstore = store;
      bus.dREN   = (kind == K_DREAD) || (kind == K_DBOTH);
      bus.dWEN   = is_write;
    end
    step();
    clear_requests();
    for (int c = 1; c < done_cyc; c++) begin
      check_output("access ram_REN", 32'(bus.ram_REN), 32'(is_read));
      check_output("access ram_WEN", 32'(bus.ram_WEN), 32'(is_write));
      check_output("access ram_addr", bus.ram_addr, addr);
      if (is_write) begin
        check_output("access ram_store", bus.ram_store, store);
      end
      check_output("access hits", {29'd0, bus.ihit, bus.dhit, bus.err}, 32'd0);
      bus.ram_ready = (c == 1 + waits);
      bus.ram_load  = bus.ram_ready ? rdata : $urandom;
      step();
    end
    bus.ram_ready = 1'b0;
    bus.ram_load  = $urandom;
    check_output("done ihit", 32'(bus.ihit), 32'(exp_ihit));
    check_output("done dhit", 32'(bus.dhit), 32'(exp_dhit));
    check_output("done err", 32'(bus.err), 32'(exp_err));
    check_output("done iload", bus.iload, exp_iload);
    check_output("done dload", bus.dload, exp_dload);
    check_output("done strobes", {30'd0, bus.ram_REN, bus.ram_WEN}, 32'd0);
    step();
    check_quiet("idle");
  endtask

  // Transaction-level reference: abort after MAX_WAIT misses, otherwise the
  // hit lands two cycles plus the wait count after the request is sampled.
  task automatic model_txn(input int kind, input logic [31:0] addr, input logic [31:0] store,
                           input logic [31:0] rdata, input int waits);
    logic aborted;
    int   done_cyc;
    aborted  = (waits >= MAX_WAIT);
    done_cyc = aborted ? MAX_WAIT + 1 : waits + 2;
    if (!aborted && kind == K_IREAD) model_iload = rdata;
    if (!aborted && kind == K_DREAD) model_dload = rdata;
    apply_stimulus(kind, addr, store, rdata, waits,
                   !aborted && (kind == K_IREAD), !aborted && (kind != K_IREAD), aborted,
                   done_cyc, model_iload, model_dload);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    step();
    step();
    nRST = 1'b1;
    model_iload = '0;
    model_dload = '0;
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    nRST     = 1'b0;
    bus.ram_ready = 1'b0;
    bus.ram_load  = '0;
    clear_requests();

    //            kind      addr        store         rdata         w  ih dh er cyc iload         dload
    vecs[0] = '{K_IREAD,  32'h40,  32'h0,         32'h2008_0005, 0, 1, 0, 0, 2, 32'h2008_0005, 32'h0};
    vecs[1] = '{K_DREAD,  32'h200, 32'h0,         32'h1234_5678, 3, 0, 1, 0, 5, 32'h2008_0005, 32'h1234_5678};
    vecs[2] = '{K_DWRITE, 32'h104, 32'hCAFE_F00D, 32'h1111_1111, 1, 0, 1, 0, 3, 32'h2008_0005, 32'h1234_5678};
    vecs[3] = '{K_DBOTH,  32'h108, 32'h0BAD_F00D, 32'h2222_2222, 0, 0, 1, 0, 2, 32'h2008_0005, 32'h1234_5678};
    vecs[4] = '{K_DREAD,  32'h20C, 32'h0,         32'hA5A5_A5A5, 3, 0, 1, 0, 5, 32'h2008_0005, 32'hA5A5_A5A5};
    vecs[5] = '{K_DREAD,  32'h210, 32'h0,         32'h5A5A_5A5A, 4, 0, 0, 1, 5, 32'h2008_0005, 32'hA5A5_A5A5};
    vecs[6] = '{K_IREAD,  32'h44,  32'h0,         32'h7777_7777, 7, 0, 0, 1, 5, 32'h2008_0005, 32'hA5A5_A5A5};
    vecs[7] = '{K_IREAD,  32'h48,  32'h0,         32'h0000_FFFF, 2, 1, 0, 0, 4, 32'h0000_FFFF, 32'hA5A5_A5A5};

    // Reset state, checked while reset is still asserted.
    step();
    step();
    check_quiet("reset");
    check_output("reset ram_addr", bus.ram_addr, 32'd0);
    check_output("reset ram_store", bus.ram_store, 32'd0);
    check_output("reset iload", bus.iload, 32'd0);
    check_output("reset dload", bus.dload, 32'd0);
    nRST = 1'b1;
    step();

    // Directed table.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].kind, vecs[i].addr, vecs[i].store, vecs[i].rdata, vecs[i].waits,
                     vecs[i].exp_ihit, vecs[i].exp_dhit, vecs[i].exp_err, vecs[i].done_cyc,
                     vecs[i].exp_iload, vecs[i].exp_dload);
    end
    model_iload = 32'h0000_FFFF;
    model_dload = 32'hA5A5_A5A5;

    // Simultaneous requests: data write first, instruction only after DONE.
    bus.iREN = 1'b1;  bus.iaddr = 32'h4;
    bus.dWEN = 1'b1;  bus.daddr = 32'h100;  bus.dstore = 32'hDEAD_BEEF;
    step();
    check_output("sim ram_WEN", 32'(bus.ram_WEN), 32'd1);
    check_output("sim ram_REN", 32'(bus.ram_REN), 32'd0);
    check_output("sim ram_addr", bus.ram_addr, 32'h100);
    check_output("sim ram_store", bus.ram_store, 32'hDEAD_BEEF);
    bus.dWEN = 1'b0;
    step();
    step();
    bus.ram_ready = 1'b1;
    bus.ram_load  = 32'h3333_3333;
    step();
    bus.ram_ready = 1'b0;
    check_output("sim dhit", 32'(bus.dhit), 32'd1);
    check_output("sim ihit", 32'(bus.ihit), 32'd0);
    check_output("sim dload", bus.dload, model_dload);
    step();
    check_quiet("sim turnaround");
    step();
    check_output("sim iacc ram_REN", 32'(bus.ram_REN), 32'd1);
    check_output("sim iacc ram_addr", bus.ram_addr, 32'h4);
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b1;
    bus.ram_load  = 32'h0404_0404;
    step();
    bus.ram_ready = 1'b0;
    check_output("sim ihit", 32'(bus.ihit), 32'd1);
    check_output("sim iload", bus.iload, 32'h0404_0404);
    model_iload = 32'h0404_0404;
    step();

    // Watchdog abort with the request still high: err, then a retry.
    bus.iREN = 1'b1;  bus.iaddr = 32'h80;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      step();
      check_output("wd strobe", 32'(bus.ram_REN), 32'd1);
    end
    step();
    check_output("wd err", 32'(bus.err), 32'd1);
    check_output("wd ihit", 32'(bus.ihit), 32'd0);
    check_output("wd iload", bus.iload, model_iload);
    step();
    check_quiet("wd turnaround");
    step();
    check_output("wd retry ram_REN", 32'(bus.ram_REN), 32'd1);
    check_output("wd retry ram_addr", bus.ram_addr, 32'h80);
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b1;
    bus.ram_load  = 32'h8888_0001;
    step();
    bus.ram_ready = 1'b0;
    check_output("wd retry ihit", 32'(bus.ihit), 32'd1);
    check_output("wd retry iload", bus.iload, 32'h8888_0001);
    model_iload = 32'h8888_0001;
    step();

    // Reset in the middle of a data access.
    bus.dREN = 1'b1;  bus.daddr = 32'h300;
    step();
    check_output("rst mid ram_REN", 32'(bus.ram_REN), 32'd1);
    bus.dREN = 1'b0;
    nRST = 1'b0;
    step();
    check_quiet("rst mid");
    check_output("rst mid ram_addr", bus.ram_addr, 32'd0);
    check_output("rst mid ram_store", bus.ram_store, 32'd0);
    check_output("rst mid iload", bus.iload, 32'd0);
    check_output("rst mid dload", bus.dload, 32'd0);
    nRST = 1'b1;
    bus.ram_ready = 1'b1;
    bus.ram_load  = 32'h9999_9999;
    for (int c = 0; c < 3; c++) begin
      step();
      check_quiet("rst after");
    end
    bus.ram_ready = 1'b0;
    model_iload = '0;
    model_dload = '0;

    // Randomized transactions against the timing model.
    for (int n = 0; n < 40; n++) begin
      model_txn($urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom_range(0, 6));
    end

`ifdef MEM_ARB_PERF_EN
    // Counters: three instruction reads with one wait, one write with none.
    do_reset();
    step();
    check_output("perf reset icount", bus.icount, 32'd0);
    for (int n = 0; n < 3; n++) begin
      model_txn(K_IREAD, 32'h500 + 32'(n * 4), 32'h0, $urandom, 1);
    end
    model_txn(K_DWRITE, 32'h600, 32'h1357_9BDF, 32'h0, 0);
    check_output("perf icount", bus.icount, 32'd3);
    check_output("perf dcount", bus.dcount, 32'd1);
    check_output("perf stall_cnt", bus.stall_cnt, 32'd3);
`else
    do_reset();
    step();
    check_quiet("final reset");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the datapath's instruction-fetch and data-access requests.
- Sits between the datapath's request signals and one shared RAM port.
- Serialises accesses with data-over-instruction priority, returns registered hit pulses with load data, and flags accesses the RAM never acknowledges (watchdog).

Parameters:
WORD_W, 32, address and data width in bits
MAX_WAIT, 15, number of consecutive not-ready cycles in an access state before watchdog abort (1..255)

Ports:
CLK  input  1  clock, all state updates on rising edge
nRST  input  1  synchronous active-low reset
iREN  input  1  instruction read request
iaddr  input  WORD_W  instruction address
iload  output  WORD_W  instruction read data, valid when ihit=1, held until next instruction completion
ihit  output  1  one-cycle instruction completion pulse
dREN  input  1  data read request
dWEN  input  1  data write request
daddr  input  WORD_W  data address
dstore  input  WORD_W  data write value
dload  output  WORD_W  data read data, valid when dhit=1 after a read, held until next data-read completion
dhit  output  1  one-cycle data completion pulse (read or write)
ram_REN  output  1  RAM read strobe
ram_WEN  output  1  RAM write strobe
ram_addr  output  WORD_W  RAM address
ram_store  output  WORD_W  RAM write data
ram_load  input  WORD_W  RAM read data, valid with ram_ready
ram_ready  input  1  RAM access complete this cycle
err  output  1  one-cycle watchdog abort pulse

Behaviour:
- Clock and reset: one clock CLK; reset nRST is synchronous and active-low.
- Reset: on any rising edge with nRST=0, FSM goes to IDLE and all outputs and registers clear to 0 (iload, dload, ram_addr, ram_store, wait counter). This applies mid-access: the in-flight access is dropped with no hit and no err.
- States: IDLE, IACC, DACC, DONE.
- IDLE:
  - If dREN|dWEN: latch daddr and dstore into ram_addr/ram_store, latch op, go to DACC.
  - Else if iREN: latch iaddr into ram_addr, go to IACC.
  - Else stay in IDLE.
  - Data always wins a simultaneous request.
  - dREN and dWEN both high is treated as a write.
- IACC: ram_REN=1, ram_WEN=0.
- DACC: ram_REN=!op_write, ram_WEN=op_write.
- All other states: ram_REN=ram_WEN=0; ram_addr and ram_store hold their last latched values.
- In IACC/DACC, on ram_ready=1:
  - Capture ram_load into iload (IACC) or into dload (DACC read only; a write leaves dload unchanged).
  - Set the pending hit type, clear the wait counter, go to DONE.
- In IACC/DACC, on ram_ready=0: wait counter increments.
  - If the counter equals MAX_WAIT-1 on a not-ready cycle, abort: go to DONE with an error flag, no data capture.
  - So MAX_WAIT not-ready cycles abort.
- DONE: lasts exactly one cycle.
  - ihit or dhit=1 for a normal completion; err=1 with both hits 0 for an abort.
  - Next state is always IDLE.
  - Requests are not sampled in DONE. This is a turnaround cycle that lets the requester deassert.
- Latency: request sampled in IDLE at cycle 0, strobe in cycle 1; if ram_ready arrives in cycle 1+k, the hit appears in cycle 2+k. Minimum request-to-hit is 2 cycles.
- No preemption: a data request arriving during IACC waits until IACC completes and the following DONE.
- Requests are level-sensitive. A request still high in IDLE after its DONE is serviced again.
- ihit, dhit and err are mutually exclusive and never high outside DONE.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs icount, dcount and stall_cnt, each WORD_W wide, all reset to 0.
  - icount increments on each ihit, dcount on each dhit.
  - stall_cnt increments on each IACC/DACC cycle with ram_ready=0.
  - All three saturate at all-ones.
- Undefined: these ports and their registers do not exist; the rest of the behaviour is identical.

Test Plan:
- Instruction read, no contention: iREN=1, iaddr=0x0000_0040, ram_ready=1 on the first strobe cycle, ram_load=0x2008_0005 -> ram_REN=1 with ram_addr=0x40 in cycle 1; ihit=1 with iload=0x2008_0005 in cycle 2; IDLE in cycle 3.
- Simultaneous requests: iREN=1 at 0x4 and dWEN=1 at daddr=0x100 with dstore=0xDEAD_BEEF, ready after 2 wait cycles -> ram_WEN first with addr 0x100 and store 0xDEADBEEF, then dhit; the instruction access starts only after DONE; ihit follows; dload unchanged.
- Data read with waits: dREN=1, daddr=0x200, ram_ready low 3 cycles then high with 0x1234_5678 -> dhit=1 and dload=0x12345678 exactly 5 cycles after request sampling; ihit stays 0.
- Watchdog: MAX_WAIT=4, iREN=1, ram_ready held 0 -> err=1 for one cycle in the cycle after the 4th not-ready cycle; no ihit; iload unchanged; then IDLE and retry on the still-high iREN.
- Reset mid-access: assert nRST=0 during DACC -> at the next edge ram_REN=ram_WEN=0 and all outputs 0; no dhit or err after release.
- MEM_ARB_PERF_EN: 3 instruction reads each with 1 wait cycle plus 1 data write with 0 waits -> icount=3, dcount=1, stall_cnt=3.
